// File: rtl/logic_arb_pkg.sv
// logic_arb_pkg: opcode encoding and response-stage state shared by the
// logic_op_arbiter slice.
package logic_arb_pkg;

  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] OP_AND  = 2'b00;
  localparam logic [OP_W-1:0] OP_OR   = 2'b01;
  localparam logic [OP_W-1:0] OP_XOR  = 2'b10;
  localparam logic [OP_W-1:0] OP_NAND = 2'b11;

  // Occupancy of the single-entry response register.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick. The first asserted
// request at or after ptr wins, searching upward with wrap-around.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  index
);

  // Walk the requesters starting at ptr and keep only the first hit.
  always_comb begin
    int  cand;
    logic found;
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: shares one registered AND/OR/XOR/NAND unit between
// N_REQ requesters with round-robin arbitration and an id-tagged response.
// Optional feature: define LOGIC_ARB_ZERO_FLAG_EN to add the rsp_zero output.
module logic_op_arbiter
  import logic_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*OP_W-1:0]  req_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id
`ifdef LOGIC_ARB_ZERO_FLAG_EN
  ,
  output logic                   rsp_zero
`endif
);

  rsp_state_t        state;
  rsp_state_t        state_next;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   ptr_next;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              slot_free;
  logic              accept;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic [OP_W-1:0]   sel_op;
  logic [WIDTH-1:0]  result;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .index (grant_idx)
  );

  assign rsp_valid = (state == ST_FULL);
  assign slot_free = ~rsp_valid | rsp_ready;
  assign req_ready = rst ? '0 : (grant & {N_REQ{slot_free}});
  assign accept    = |(req_valid & req_ready);
  assign ptr_next  = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  // Select the granted requester's operands and evaluate the logic function.
  always_comb begin
    sel_a  = req_a[int'(grant_idx)*WIDTH +: WIDTH];
    sel_b  = req_b[int'(grant_idx)*WIDTH +: WIDTH];
    sel_op = req_op[int'(grant_idx)*OP_W +: OP_W];
    result = '0;
    case (sel_op)
      OP_AND:  result = sel_a & sel_b;
      OP_OR:   result = sel_a | sel_b;
      OP_XOR:  result = sel_a ^ sel_b;
      OP_NAND: result = ~(sel_a & sel_b);
      default: result = '0;
    endcase
  end

  // Response slot occupancy: fill on accept, drain on consume without refill.
  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: if (accept) state_next = ST_FULL;
      ST_FULL:  if (rsp_ready && !accept) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  // Response slot state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Capture result, id and advance the round-robin pointer on every accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data <= '0;
      rsp_id   <= '0;
      ptr      <= '0;
    end else if (accept) begin
      rsp_data <= result;
      rsp_id   <= grant_idx;
      ptr      <= ptr_next;
    end
  end

`ifdef LOGIC_ARB_ZERO_FLAG_EN
  // Zero flag travels with the captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_zero <= 1'b0;
    end else if (accept) begin
      rsp_zero <= (result == '0);
    end
  end
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb_logic_op_arbiter: directed vector table, a back-to-back sequence and a
// randomized run against a queue-based reference of logic_op_arbiter.
// Honours LOGIC_ARB_ZERO_FLAG_EN when defined.
module tb_logic_op_arbiter;
  import logic_arb_pkg::*;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int ID_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ*2-1:0]     req_op;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDTH-1:0]       rsp_data;
  logic [ID_W-1:0]        rsp_id;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
  logic                   rsp_zero;
`endif

  int total = 0;
  int bad   = 0;

  logic_op_arbiter #(
    .N_REQ (N_REQ),
    .WIDTH (WIDTH),
    .ID_W  (ID_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    ,
    .rsp_zero  (rsp_zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  op;
    logic        rr;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic [1:0]  exp_id;
  } vec_t;

  vec_t vecs[$];
  vec_t v;

  function automatic void add_vec(input logic r, input logic [3:0] vl, input logic [31:0] a,
                                  input logic [31:0] b, input logic [7:0] op, input logic rr,
                                  input logic [3:0] er, input logic ev, input logic [7:0] ed,
                                  input logic [1:0] ei);
    vec_t t;
    t.rst = r; t.valid = vl; t.a = a; t.b = b; t.op = op; t.rr = rr;
    t.exp_ready = er; t.exp_valid = ev; t.exp_data = ed; t.exp_id = ei;
    vecs.push_back(t);
  endfunction

  function automatic logic [7:0] ref_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    if (op == 2'd0) r = a & b;
    else if (op == 2'd1) r = a | b;
    else if (op == 2'd2) r = a ^ b;
    else r = ~(a & b);
    return r;
  endfunction

  task automatic apply_stimulus(input logic r, input logic [3:0] vl, input logic [31:0] a,
                                input logic [31:0] b, input logic [7:0] op, input logic rr);
    rst       = r;
    req_valid = vl;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    rsp_ready = rr;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model state for the randomized phase.
  logic [7:0] m_q[$];
  int         m_ptr;
  logic [7:0] m_data;
  logic [1:0] m_id;
  logic       m_zero;
  bit         rv[N_REQ];
  logic [7:0] ra[N_REQ];
  logic [7:0] rb[N_REQ];
  logic [1:0] rop[N_REQ];

  initial begin
    logic tbl_zero;
    logic r_rst, r_rr, slot;
    int   winner;
    int   id;
    logic [3:0]  exp_ready;
    logic [31:0] pa, pb;
    logic [7:0]  pop;
    logic [7:0]  res;

    apply_stimulus(1'b1, 4'h0, 32'h0, 32'h0, 8'h0, 1'b0);
    #1;

    // Directed table: reset, opcodes, rotation, wrap, backpressure, reset mid-flight, zero.
    add_vec(1, 4'hF, 32'h0, 32'h0, 8'h00, 1, 4'h0, 0, 8'h00, 2'd0);
    add_vec(1, 4'h0, 32'h0, 32'h0, 8'h00, 1, 4'h0, 0, 8'h00, 2'd0);
    add_vec(0, 4'h1, 32'h000000F0, 32'h0000003C, 8'h00, 1, 4'h1, 1, 8'h30, 2'd0);
    add_vec(0, 4'h2, 32'h0000AA00, 32'h00000F00, 8'h04, 1, 4'h2, 1, 8'hAF, 2'd1);
    add_vec(0, 4'h4, 32'h00AA0000, 32'h000F0000, 8'h20, 1, 4'h4, 1, 8'hA5, 2'd2);
    add_vec(0, 4'h8, 32'hAA000000, 32'h0F000000, 8'hC0, 1, 4'h8, 1, 8'hF5, 2'd3);
    add_vec(0, 4'hF, 32'h44332211, 32'hF00FFF00, 8'h84, 1, 4'h1, 1, 8'h00, 2'd0);
    add_vec(0, 4'hF, 32'h44332211, 32'hF00FFF00, 8'h84, 1, 4'h2, 1, 8'hFF, 2'd1);
    add_vec(0, 4'hF, 32'h44332211, 32'hF00FFF00, 8'h84, 1, 4'h4, 1, 8'h03, 2'd2);
    add_vec(0, 4'hF, 32'h44332211, 32'hF00FFF00, 8'h84, 1, 4'h8, 1, 8'hB4, 2'd3);
    add_vec(0, 4'hF, 32'h44332211, 32'hF00FFF00, 8'h84, 1, 4'h1, 1, 8'h00, 2'd0);
    add_vec(0, 4'h8, 32'h44332211, 32'hF00FFF00, 8'h84, 1, 4'h8, 1, 8'hB4, 2'd3);
    add_vec(0, 4'h2, 32'h0000120F, 32'h000034FF, 8'h01, 1, 4'h2, 1, 8'h10, 2'd1);
    add_vec(0, 4'h3, 32'h0000120F, 32'h000034FF, 8'h01, 1, 4'h1, 1, 8'hFF, 2'd0);
    add_vec(0, 4'h2, 32'h0000120F, 32'h000034FF, 8'h01, 1, 4'h2, 1, 8'h10, 2'd1);
    add_vec(0, 4'h0, 32'h0000120F, 32'h000034FF, 8'h01, 1, 4'h0, 0, 8'h10, 2'd1);
    add_vec(0, 4'hC, 32'hC3C30000, 32'h3C3C0000, 8'h20, 1, 4'h4, 1, 8'hFF, 2'd2);
    add_vec(0, 4'hC, 32'hC3C30000, 32'h3C3C0000, 8'h20, 0, 4'h0, 1, 8'hFF, 2'd2);
    add_vec(0, 4'hC, 32'hC3C30000, 32'h3C3C0000, 8'h20, 0, 4'h0, 1, 8'hFF, 2'd2);
    add_vec(0, 4'hC, 32'hC3C30000, 32'h3C3C0000, 8'h20, 0, 4'h0, 1, 8'hFF, 2'd2);
    add_vec(0, 4'hC, 32'hC3C30000, 32'h3C3C0000, 8'h20, 1, 4'h8, 1, 8'h00, 2'd3);
    add_vec(0, 4'h4, 32'hC3C30000, 32'h3C3C0000, 8'h20, 1, 4'h4, 1, 8'hFF, 2'd2);
    add_vec(1, 4'hF, 32'hC3C30000, 32'h3C3C0000, 8'h20, 0, 4'h0, 0, 8'h00, 2'd0);
    add_vec(0, 4'h5, 32'h0000005A, 32'h000000FF, 8'h02, 1, 4'h1, 1, 8'hA5, 2'd0);
    add_vec(0, 4'h2, 32'h00005500, 32'h0000AA00, 8'h00, 1, 4'h2, 1, 8'h00, 2'd1);
    add_vec(0, 4'h4, 32'h00550000, 32'h00AA0000, 8'h10, 1, 4'h4, 1, 8'hFF, 2'd2);

    tbl_zero = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      apply_stimulus(v.rst, v.valid, v.a, v.b, v.op, v.rr);
      #1;
      check_output($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(v.exp_ready));
      @(posedge clk);
      #1;
      check_output($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(v.exp_valid));
      check_output($sformatf("vec%0d rsp_data", i), 32'(rsp_data), 32'(v.exp_data));
      check_output($sformatf("vec%0d rsp_id", i), 32'(rsp_id), 32'(v.exp_id));
      if (v.rst) tbl_zero = 1'b0;
      else if (v.exp_ready != 4'h0) tbl_zero = (v.exp_data == 8'h00);
`ifdef LOGIC_ARB_ZERO_FLAG_EN
      check_output($sformatf("vec%0d rsp_zero", i), 32'(rsp_zero), 32'(tbl_zero));
`endif
    end

    // Back-to-back: all requesters valid, OR with zero returns each requester's A.
    // Pointer sits at 3 after the table, so ids rotate 3,0,1,2,...
    for (int k = 0; k < 8; k++) begin
      id = (3 + k) % N_REQ;
      apply_stimulus(1'b0, 4'hF, 32'h44332211, 32'h00000000, 8'h55, 1'b1);
      #1;
      check_output($sformatf("b2b%0d req_ready", k), 32'(req_ready), 32'(1 << id));
      @(posedge clk);
      #1;
      check_output($sformatf("b2b%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
      check_output($sformatf("b2b%0d rsp_id", k), 32'(rsp_id), 32'(id));
      check_output($sformatf("b2b%0d rsp_data", k), 32'(rsp_data), 32'(8'h11 * (id + 1)));
    end

    // Randomized run against the reference model.
    m_q.delete();
    m_ptr = 0; m_data = 8'h00; m_id = 2'd0; m_zero = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      rv[i] = 1'b0; ra[i] = 8'h00; rb[i] = 8'h00; rop[i] = 2'd0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      r_rst = (cyc == 0) || ($urandom_range(0, 63) == 0);
      r_rr  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N_REQ; i++) begin
        if (!rv[i]) begin
          rv[i]  = ($urandom_range(0, 1) == 1);
          ra[i]  = 8'($urandom);
          rb[i]  = 8'($urandom);
          rop[i] = 2'($urandom_range(0, 3));
        end
      end
      pa = '0; pb = '0; pop = '0;
      for (int i = 0; i < N_REQ; i++) begin
        pa[i*8 +: 8]  = ra[i];
        pb[i*8 +: 8]  = rb[i];
        pop[i*2 +: 2] = rop[i];
      end
      apply_stimulus(r_rst, {rv[3], rv[2], rv[1], rv[0]}, pa, pb, pop, r_rr);
      #1;
      slot   = (m_q.size() == 0) || r_rr;
      winner = -1;
      for (int k = 0; k < N_REQ; k++) begin
        if (winner < 0 && rv[(m_ptr + k) % N_REQ]) winner = (m_ptr + k) % N_REQ;
      end
      exp_ready = (!r_rst && slot && winner >= 0) ? 4'(1 << winner) : 4'h0;
      check_output($sformatf("rnd%0d req_ready", cyc), 32'(req_ready), 32'(exp_ready));
      @(posedge clk);
      #1;
      if (r_rst) begin
        m_q.delete();
        m_ptr = 0; m_data = 8'h00; m_id = 2'd0; m_zero = 1'b0;
      end else begin
        if (m_q.size() > 0 && r_rr) void'(m_q.pop_front());
        if (exp_ready != 4'h0) begin
          res = ref_op(rop[winner], ra[winner], rb[winner]);
          m_q.push_back(res);
          m_data = res;
          m_id   = 2'(winner);
          m_zero = (res == 8'h00);
          m_ptr  = (winner + 1) % N_REQ;
          rv[winner] = 1'b0;
        end
      end
      check_output($sformatf("rnd%0d rsp_valid", cyc), 32'(rsp_valid), 32'(m_q.size() != 0));
      check_output($sformatf("rnd%0d rsp_data", cyc), 32'(rsp_data), 32'(m_data));
      check_output($sformatf("rnd%0d rsp_id", cyc), 32'(rsp_id), 32'(m_id));
`ifdef LOGIC_ARB_ZERO_FLAG_EN
      check_output($sformatf("rnd%0d rsp_zero", cyc), 32'(rsp_zero), 32'(m_zero));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
